restoring_divider: RTL
======================

RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal 4..16).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 dividend  input  WIDTH  unsigned numerator; captured on the accepted start.
REQ-006 divisor  input  WIDTH  unsigned denominator; captured on the accepted start.
REQ-007 busy  output  1  high in RUN and DONE states.
REQ-008 done  output  1  one-cycle pulse; results valid.
REQ-009 quotient  output  WIDTH  unsigned quotient; held until the next accepted start.
REQ-010 remainder  output  WIDTH  unsigned remainder; held until the next accepted start.
REQ-011 div_by_zero  output  1  flag for the last completed operation; held with the results.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 Transitions SHALL be:
- IDLE->RUN when start=1 and divisor!=0.
- IDLE->DONE when start=1 and divisor=0.
- RUN->DONE after exactly WIDTH iterations.
- DONE->IDLE unconditionally.
REQ-014 An accepted start SHALL copy the operands into internal registers, clear the partial remainder, and load the iteration counter with WIDTH.
REQ-015 Each RUN cycle SHALL perform one restoring step:
- shift the partial remainder left by 1, bringing in the dividend MSB;
- compute a trial subtraction of the divisor at width WIDTH+1;
- if the result is non-negative, keep it and shift a 1 into the quotient, else restore and shift in 0;
- decrement the counter.
REQ-016 Latency from the start-accept edge to done high SHALL be WIDTH+1 cycles (9 for WIDTH=8) when divisor!=0, and 1 cycle when divisor=0.
REQ-017 On DONE entry, quotient, remainder and div_by_zero SHALL update together.
REQ-018 done SHALL be high for exactly the DONE cycle.
REQ-019 Divide by zero SHALL give quotient = all ones, remainder = dividend, and div_by_zero=1.
REQ-020 start SHALL be ignored while busy=1, including the DONE cycle; operand changes during busy SHALL have no effect.
REQ-021 The next operation SHALL be accepted no earlier than the cycle after done.
REQ-022 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor, for all nonzero divisors.

Reset
REQ-023 When rst_n=0 at a rising edge, the block SHALL enter IDLE and clear busy, done, quotient, remainder, div_by_zero, the counter and all internal registers to 0.
REQ-024 Reset SHALL take precedence over start.
REQ-025 Reset during RUN or DONE SHALL abort the operation with no done pulse.
REQ-026 After rst_n returns high, the first start SHALL be accepted normally.

Structure
REQ-027 A shared package div_pkg SHALL hold the FSM state enumeration and the default WIDTH constant.
REQ-028 One combinational sub-module, div_step, SHALL implement the shift / trial-subtract / restore step (inputs: partial remainder, dividend MSB, divisor; outputs: next remainder, quotient bit).
REQ-029 All sequential logic SHALL reside in restoring_divider.

Verification
REQ-030 100/7 with start at edge 0 -> done at edge 9, quotient=14, remainder=2, div_by_zero=0.
REQ-031 255/1 -> quotient=255, remainder=0; 3/10 -> quotient=0, remainder=3; 255/255 -> quotient=1, remainder=0.
REQ-032 5/0 -> done one cycle after accept, quotient=255, remainder=5, div_by_zero=1; a following 9/3 -> quotient=3, remainder=0, div_by_zero=0.
REQ-033 start=1 with 50/5 at cycle 3 of a 100/7 run -> ignored; results 14/2; done pulses once.
REQ-034 rst_n=0 at cycle 4 of a RUN -> all outputs 0 next cycle, no done pulse; then 20/6 -> quotient=3, remainder=2.
REQ-035 Randomized check, 1000 operand pairs against the REQ-022 identity, with start asserted every cycle -> exactly one done per accepted start.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and defaults for the restoring divider.
package div_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in the dividend MSB, trial-subtract, restore on borrow.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             qbit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor keeps shifted below 2*divisor, so trial[WIDTH] is a reliable borrow flag
    always_comb begin
        shifted  = {rem, msb};
        trial    = shifted - {1'b0, divisor};
        qbit     = ~trial[WIDTH];
        next_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per RUN cycle, results held until next start.
module restoring_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned   CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] ITER = CW'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] next_rem;
    logic             qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .msb      (dvd[WIDTH-1]),
        .divisor  (dvs),
        .next_rem (next_rem),
        .qbit     (qbit)
    );

    // dvd doubles as the quotient shift register: dividend bits leave at the top, quotient bits enter at the bottom
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd  <= dividend;
                        dvs  <= divisor;
                        rem  <= '0;
                        cnt  <= ITER;
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    dvd <= {dvd[WIDTH-2:0], qbit};
                    rem <= next_rem;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        quotient    <= {dvd[WIDTH-2:0], qbit};
                        remainder   <= next_rem;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
